jtag_dm_mem_responder: RTL and testbench
========================================

Name: jtag_dm_mem_responder

Overview:
- Responder for the debug module's bus-master port (req_valid / req_ready / rsp_valid / rsp_ready, plus mem_we / addr / wdata / sel / rdata).
- Accepts one DM memory request at a time and performs it on a single-port synchronous RAM.
- Returns read data or completion with an error flag.
- Sits between the debug module and the RAM, so the debugger can read and load memory while the core is halted.

Parameters:
- RAM_BASE, 32'h1000_0000, byte address of RAM word 0.
- RAM_AW, 12, RAM word-address width; RAM holds 2^RAM_AW words.
- WAIT_CYCLES, 0, extra stall cycles inserted after each RAM access (0..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req_valid_i  input  1  DM request valid
- req_ready_o  output  1  responder can accept a request
- req_we_i  input  1  1 = write, 0 = read
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  write data
- req_sel_i  input  4  byte enables
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  DM accepts response
- rsp_rdata_o  output  32  read data
- rsp_err_o  output  1  address out of range
- ram_en_o  output  1  RAM access strobe, one cycle
- ram_we_o  output  1  RAM write
- ram_addr_o  output  RAM_AW  RAM word address
- ram_wdata_o  output  32  RAM write data
- ram_be_o  output  4  RAM byte enables
- ram_rdata_i  input  32  RAM read data, valid the cycle after ram_en_o

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low on rst_n. All state changes on the rising edge of clk.
- Reset values: state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_err_o=0; rsp_rdata_o=0; ram_en_o=0; ram_we_o=0; ram_addr_o=0; ram_wdata_o=0; ram_be_o=0; wait counter=0.
- States: IDLE, ACCESS, CAPTURE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - Handshake occurs at cycle T when req_valid_i && req_ready_o; all request fields are registered at that edge.
  - In range means RAM_BASE <= addr < RAM_BASE + 4*2^RAM_AW, using 33-bit arithmetic with no wrap.
  - In range -> ACCESS.
  - Out of range -> RESP with rsp_err_o=1 and rsp_rdata_o=0; rsp_valid_o=1 at T+1; no RAM access.
- ACCESS (cycle T+1):
  - ram_en_o=1, ram_we_o=req_we.
  - ram_addr_o = (addr - RAM_BASE) >> 2, truncated to RAM_AW bits. addr[1:0] is ignored; alignment is expressed through sel.
  - ram_wdata_o = wdata. ram_be_o = sel when writing, 4'b0000 when reading.
  - Next state: CAPTURE.
- CAPTURE (T+2):
  - ram_en_o=0.
  - Read: rsp_rdata_o <= ram_rdata_i (full word, unshifted). Write: rsp_rdata_o <= 0.
  - Next state: WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: counts WAIT_CYCLES cycles, then goes to RESP.
- Response latency: rsp_valid_o first high at T+3+WAIT_CYCLES for in-range requests; T+1 for errors.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i=1.
  - On rsp_valid_o && rsp_ready_i -> IDLE: rsp_valid_o=0 and rsp_err_o=0 the next cycle, and req_ready_o=1 in that same next cycle.
- req_ready_o is 0 in every state except IDLE. Exactly one request is outstanding; requests are never queued.
- req_valid_i asserted while req_ready_o=0 is ignored; the DM must hold the request.
- rsp_ready_i already high when rsp_valid_o rises completes the response in one cycle.
- A write with sel=0000 still issues ram_en_o with ram_be_o=0000 and returns a normal response.
- ram_en_o is never high for more than one consecutive cycle per request.
- Reset mid-operation: state returns to IDLE and all outputs take reset values on the next edge; the pending request is dropped with no response. A RAM write already strobed is not undone.

Test Plan:
- Write then read, WAIT_CYCLES=0:
  - Write addr 0x1000_0010, wdata 0xDEADBEEF, sel 1111 -> ram_en_o at T+1 with ram_addr_o=4, ram_be_o=1111; rsp_valid_o at T+3, rsp_err_o=0.
  - Read of the same address -> rsp_rdata_o=0xDEADBEEF at T+3.
- Byte write: sel 0010, wdata 0x0000AB00 to 0x1000_0011 -> ram_addr_o=4, ram_be_o=0010; a following read returns 0xDEADABEF.
- Out of range: read 0x0FFF_FFFC -> rsp_valid_o at T+1, rsp_err_o=1, rsp_rdata_o=0, ram_en_o never asserted. Same for 0x1000_4000 with RAM_AW=12.
- Response backpressure: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable throughout; req_ready_o=0 throughout; req_ready_o=1 the cycle after the handshake.
- Wait states: WAIT_CYCLES=3 -> rsp_valid_o first high at T+6; ram_en_o high only at T+1.
- Reset mid-op: rst_n low at T+2 of a read -> next cycle rsp_valid_o=0, req_ready_o=1; no response is ever issued; a following request completes normally.

Source files
------------

// File: rtl/jtag_dm_mem_responder_if.sv
// Debug-module bus-master port: one request channel and one response channel,
// each with its own valid/ready pair.
interface jtag_dm_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/jtag_dm_mem_responder.sv
// Serves one debug-module memory request at a time on a single-port synchronous
// RAM, returning read data or completion with an out-of-range error flag.
module jtag_dm_mem_responder #(
  parameter logic [31:0] RAM_BASE    = 32'h1000_0000,
  parameter int unsigned RAM_AW      = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  jtag_dm_mem_responder_if.slave    dm,
  output logic                      ram_en_o,
  output logic                      ram_we_o,
  output logic [RAM_AW-1:0]         ram_addr_o,
  output logic [31:0]               ram_wdata_o,
  output logic [3:0]                ram_be_o,
  input  logic [31:0]               ram_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_CAPTURE = 3'd2,
    S_WAIT    = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  // Range limits carry a 33rd bit so a window touching 2^32 never wraps.
  localparam logic [32:0] RAM_LO    = {1'b0, RAM_BASE};
  localparam logic [32:0] RAM_HI    = RAM_LO + (33'd4 << RAM_AW);
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES == 32'd0) ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

  state_e             state_q,     state_d;
  logic               req_we_q,    req_we_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q,   rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               ram_en_q,    ram_en_d;
  logic               ram_we_q,    ram_we_d;
  logic [RAM_AW-1:0]  ram_addr_q,  ram_addr_d;
  logic [31:0]        ram_wdata_q, ram_wdata_d;
  logic [3:0]         ram_be_q,    ram_be_d;
  logic [3:0]         cnt_q,       cnt_d;

  logic [32:0]        addr_ext_s;
  logic [31:0]        offset_s;
  logic               in_range_s;

  assign addr_ext_s = {1'b0, dm.req_addr};
  assign offset_s   = dm.req_addr - RAM_BASE;
  assign in_range_s = (addr_ext_s >= RAM_LO) && (addr_ext_s < RAM_HI);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (dm.req_valid && req_ready_q) begin
          req_we_d    = dm.req_we;
          req_ready_d = 1'b0;
          if (in_range_s) begin
            state_d     = S_ACCESS;
            ram_en_d    = 1'b1;
            ram_we_d    = dm.req_we;
            ram_addr_d  = RAM_AW'(offset_s >> 2'd2);
            ram_wdata_d = dm.req_wdata;
            ram_be_d    = dm.req_we ? dm.req_sel : 4'b0000;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_rdata_d = req_we_q ? 32'd0 : ram_rdata_i;
        if (WAIT_CYCLES != 32'd0) begin
          state_d = S_WAIT;
          cnt_d   = 4'd0;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          cnt_d       = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (dm.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        cnt_d       = 4'd0;
      end
    endcase
  end

  // State and output registers; reset drops any pending request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_we_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'd0;
      ram_be_q    <= 4'b0000;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dm.req_ready = req_ready_q;
  assign dm.rsp_valid = rsp_valid_q;
  assign dm.rsp_err   = rsp_err_q;
  assign dm.rsp_rdata = rsp_rdata_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign ram_be_o     = ram_be_q;

endmodule

// File: tb/tb_jtag_dm_mem_responder.sv
// Directed bench: two responders (WAIT_CYCLES 0 and 3) each on a byte-enable
// RAM model; shared stimulus, per-DUT request valid, outputs muxed by 'which'.
module tb_jtag_dm_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        which;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  int          n_checks = 0;
  int          n_errors = 0;

  jtag_dm_mem_responder_if bus0();
  jtag_dm_mem_responder_if bus3();

  logic        ram_en0, ram_we0, ram_en3, ram_we3;
  logic [11:0] ram_addr0, ram_addr3;
  logic [31:0] ram_wdata0, ram_rdata0, ram_wdata3, ram_rdata3;
  logic [3:0]  ram_be0, ram_be3;
  logic [31:0] mem0 [0:4095];
  logic [31:0] mem3 [0:4095];

  assign bus0.req_valid = req_valid & ~which;
  assign bus3.req_valid = req_valid & which;
  assign bus0.req_we    = req_we;
  assign bus3.req_we    = req_we;
  assign bus0.req_addr  = req_addr;
  assign bus3.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus3.req_wdata = req_wdata;
  assign bus0.req_sel   = req_sel;
  assign bus3.req_sel   = req_sel;
  assign bus0.rsp_ready = rsp_ready;
  assign bus3.rsp_ready = rsp_ready;

  jtag_dm_mem_responder #(.RAM_BASE(32'h1000_0000), .RAM_AW(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .dm(bus0),
    .ram_en_o(ram_en0), .ram_we_o(ram_we0), .ram_addr_o(ram_addr0),
    .ram_wdata_o(ram_wdata0), .ram_be_o(ram_be0), .ram_rdata_i(ram_rdata0)
  );

  jtag_dm_mem_responder #(.RAM_BASE(32'h1000_0000), .RAM_AW(12), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .dm(bus3),
    .ram_en_o(ram_en3), .ram_we_o(ram_we3), .ram_addr_o(ram_addr3),
    .ram_wdata_o(ram_wdata3), .ram_be_o(ram_be3), .ram_rdata_i(ram_rdata3)
  );

  // RAM models: read-first, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_en0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we0 && ram_be0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
      ram_rdata0 <= mem0[ram_addr0];
    end
  end

  always @(posedge clk) begin
    if (ram_en3) begin
      for (int b = 0; b < 4; b++)
        if (ram_we3 && ram_be3[b]) mem3[ram_addr3][8*b +: 8] <= ram_wdata3[8*b +: 8];
      ram_rdata3 <= mem3[ram_addr3];
    end
  end

  logic        obs_req_ready, obs_rsp_valid, obs_rsp_err, obs_ram_en, obs_ram_we;
  logic [31:0] obs_rsp_rdata, obs_ram_wdata;
  logic [11:0] obs_ram_addr;
  logic [3:0]  obs_ram_be;
  assign obs_req_ready = which ? bus3.req_ready : bus0.req_ready;
  assign obs_rsp_valid = which ? bus3.rsp_valid : bus0.rsp_valid;
  assign obs_rsp_err   = which ? bus3.rsp_err   : bus0.rsp_err;
  assign obs_rsp_rdata = which ? bus3.rsp_rdata : bus0.rsp_rdata;
  assign obs_ram_en    = which ? ram_en3    : ram_en0;
  assign obs_ram_we    = which ? ram_we3    : ram_we0;
  assign obs_ram_addr  = which ? ram_addr3  : ram_addr0;
  assign obs_ram_wdata = which ? ram_wdata3 : ram_wdata0;
  assign obs_ram_be    = which ? ram_be3    : ram_be0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request: handshake edge T, then latency counted in cycles after T.
  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel, input int hold,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_en, input logic [11:0] exp_raddr, input logic [3:0] exp_be);
    int          lat, en_cnt, en_at;
    logic [11:0] seen_addr;
    logic [3:0]  seen_be;
    logic        seen_we;
    logic [31:0] seen_wdata;
    en_cnt = 0; en_at = 0; seen_addr = 12'd0; seen_be = 4'd0; seen_we = 1'b0; seen_wdata = 32'd0;
    rsp_ready = (hold == 0);
    @(negedge clk);
    check_eq({tag, ".idle_ready"}, {31'd0, obs_req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_sel = sel;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (obs_rsp_valid !== 1'b1 && lat < 40) begin
      check_eq({tag, ".busy_ready"}, {31'd0, obs_req_ready}, 32'd0);
      if (obs_ram_en === 1'b1) begin
        en_cnt++; en_at = lat;
        seen_addr = obs_ram_addr; seen_be = obs_ram_be; seen_we = obs_ram_we; seen_wdata = obs_ram_wdata;
      end
      @(negedge clk);
      lat++;
    end
    if (obs_ram_en === 1'b1) en_cnt++;
    check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".err"}, {31'd0, obs_rsp_err}, {31'd0, exp_err});
    check_eq({tag, ".rdata"}, obs_rsp_rdata, exp_rdata);
    check_eq({tag, ".en_cycles"}, 32'(en_cnt), exp_en ? 32'd1 : 32'd0);
    if (exp_en) begin
      check_eq({tag, ".en_at"}, 32'(en_at), 32'd1);
      check_eq({tag, ".ram_addr"}, {20'd0, seen_addr}, {20'd0, exp_raddr});
      check_eq({tag, ".ram_be"}, {28'd0, seen_be}, {28'd0, exp_be});
      check_eq({tag, ".ram_we"}, {31'd0, seen_we}, {31'd0, we});
      check_eq({tag, ".ram_wdata"}, seen_wdata, wdata);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, ".hold_valid"}, {31'd0, obs_rsp_valid}, 32'd1);
      check_eq({tag, ".hold_rdata"}, obs_rsp_rdata, exp_rdata);
      check_eq({tag, ".hold_ready"}, {31'd0, obs_req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, ".done_valid"}, {31'd0, obs_rsp_valid}, 32'd0);
    check_eq({tag, ".done_err"}, {31'd0, obs_rsp_err}, 32'd0);
    check_eq({tag, ".done_ready"}, {31'd0, obs_req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; which = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    req_addr = 32'd0; req_wdata = 32'd0; req_sel = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("rst.req_ready", {31'd0, obs_req_ready}, 32'd1);
    check_eq("rst.rsp_valid", {31'd0, obs_rsp_valid}, 32'd0);
    check_eq("rst.rsp_err",   {31'd0, obs_rsp_err},   32'd0);
    check_eq("rst.rsp_rdata", obs_rsp_rdata, 32'd0);
    check_eq("rst.ram_en",    {31'd0, obs_ram_en},    32'd0);
    check_eq("rst.ram_we",    {31'd0, obs_ram_we},    32'd0);
    check_eq("rst.ram_addr",  {20'd0, obs_ram_addr},  32'd0);
    check_eq("rst.ram_wdata", obs_ram_wdata, 32'd0);
    check_eq("rst.ram_be",    {28'd0, obs_ram_be},    32'd0);
    rst_n = 1'b1;

    run_req("wr_word",  1'b1, 32'h1000_0010, 32'hDEADBEEF, 4'b1111, 0, 3, 32'd0,        1'b0, 1'b1, 12'd4,     4'b1111);
    run_req("rd_word",  1'b0, 32'h1000_0010, 32'd0,        4'b1111, 0, 3, 32'hDEADBEEF, 1'b0, 1'b1, 12'd4,     4'b0000);
    run_req("wr_byte",  1'b1, 32'h1000_0011, 32'h0000AB00, 4'b0010, 0, 3, 32'd0,        1'b0, 1'b1, 12'd4,     4'b0010);
    run_req("rd_byte",  1'b0, 32'h1000_0010, 32'd0,        4'b1111, 0, 3, 32'hDEADABEF, 1'b0, 1'b1, 12'd4,     4'b0000);
    run_req("oor_low",  1'b0, 32'h0FFF_FFFC, 32'd0,        4'b1111, 0, 1, 32'd0,        1'b1, 1'b0, 12'd0,     4'b0000);
    run_req("oor_high", 1'b0, 32'h1000_4000, 32'd0,        4'b1111, 0, 1, 32'd0,        1'b1, 1'b0, 12'd0,     4'b0000);
    run_req("oor_wr",   1'b1, 32'hFFFF_FFFC, 32'h1111_2222, 4'b1111, 0, 1, 32'd0,       1'b1, 1'b0, 12'd0,     4'b0000);
    run_req("wr_top",   1'b1, 32'h1000_3FFC, 32'h1234_5678, 4'b1111, 0, 3, 32'd0,       1'b0, 1'b1, 12'hFFF,   4'b1111);
    run_req("rd_top",   1'b0, 32'h1000_3FFC, 32'd0,        4'b1111, 0, 3, 32'h1234_5678, 1'b0, 1'b1, 12'hFFF,  4'b0000);
    run_req("wr_sel0",  1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'b0000, 0, 3, 32'd0,       1'b0, 1'b1, 12'd4,     4'b0000);
    run_req("rd_sel0",  1'b0, 32'h1000_0010, 32'd0,        4'b1111, 0, 3, 32'hDEADABEF, 1'b0, 1'b1, 12'd4,     4'b0000);
    run_req("bp_rd",    1'b0, 32'h1000_0010, 32'd0,        4'b1111, 5, 3, 32'hDEADABEF, 1'b0, 1'b1, 12'd4,     4'b0000);
    run_req("bp_err",   1'b0, 32'h2000_0000, 32'd0,        4'b1111, 5, 1, 32'd0,        1'b1, 1'b0, 12'd0,     4'b0000);

    which = 1'b1;
    run_req("w3_wr",    1'b1, 32'h1000_0020, 32'hCAFE_F00D, 4'b1111, 0, 6, 32'd0,       1'b0, 1'b1, 12'd8,     4'b1111);
    run_req("w3_rd",    1'b0, 32'h1000_0020, 32'd0,        4'b1111, 0, 6, 32'hCAFE_F00D, 1'b0, 1'b1, 12'd8,    4'b0000);
    run_req("w3_err",   1'b0, 32'h1000_4000, 32'd0,        4'b1111, 0, 1, 32'd0,        1'b1, 1'b0, 12'd0,     4'b0000);
    which = 1'b0;

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000_0010; req_sel = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst.rsp_valid", {31'd0, obs_rsp_valid}, 32'd0);
    check_eq("midrst.req_ready", {31'd0, obs_req_ready}, 32'd1);
    check_eq("midrst.ram_en",    {31'd0, obs_ram_en},    32'd0);
    check_eq("midrst.rsp_rdata", obs_rsp_rdata, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (obs_rsp_valid === 1'b1) seen++;
    end
    check_eq("midrst.no_rsp", 32'(seen), 32'd0);
    run_req("after_rst", 1'b0, 32'h1000_0010, 32'd0, 4'b1111, 0, 3, 32'hDEADABEF, 1'b0, 1'b1, 12'd4, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
